// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   REG_ADDR_W / REG_DATA_W : register file address and data widths
//   REG_ZERO                : hardwired-zero register; writes to it are dropped
//   wb_req_t                : one pending write (destination + data)
//   reg_onehot()            : one-hot decode of a register address
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic [31:0] reg_onehot(input logic [REG_ADDR_W-1:0] a);
    return 32'd1 << a;
  endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO holding deferred register writes from the long-latency unit.
// Ports:
//   clk, rst          : clock and synchronous active-high reset (flushes contents)
//   push, wr_req      : store wr_req at the tail (ignored when full)
//   pop               : drop the head entry (ignored when empty)
//   head              : entry at the head of the queue
//   full, empty       : occupancy flags derived from the entry count
//   entry_valid/addr  : per-slot view (physical slot order) used to build the
//                       pending-write vector
import regfile_pkg::*;

module rf_wb_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                push,
  input  wb_req_t                             wr_req,
  input  logic                                pop,
  output wb_req_t                             head,
  output logic                                full,
  output logic                                empty,
  output logic [DEPTH-1:0]                    entry_valid,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= wr_req;
  end

  // A physical slot holds a live entry when its distance from the read
  // pointer is below the current count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_view
    logic [PTR_W-1:0] off;
    assign off            = PTR_W'(g) - rd_ptr;
    assign entry_valid[g] = ({1'b0, off} < count);
    assign entry_addr[g]  = mem[g].addr;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter for the 32x32 register file.
// Source A (pipeline writeback) has priority; source B (long-latency unit) is
// buffered in a FIFO and written in idle slots, with a starvation counter that
// stalls A after STARVE_LIMIT consecutive A wins while B is waiting.
// Ports:
//   clk_i, rst_i              : clock, synchronous active-high reset
//   a_valid_i/a_addr_i/a_data_i : writeback request (no handshake)
//   a_stall_o                 : pipeline must hold its A request this cycle
//   b_valid_i/b_ready_o/b_addr_i/b_data_i : B request with valid/ready handshake
//   RDaddr_o/RDdata_o/RegWrite_o : registered register-file write port
//   pend_o                    : bit i set while a buffered B entry targets reg i
//
// B handshake: a transfer happens on a rising edge where b_valid_i and
// b_ready_o are both high. b_ready_o depends only on FIFO occupancy and reset,
// never on b_valid_i. Transfers to register 0 complete but are discarded.
import regfile_pkg::*;

module regfile_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  a_valid_i,
  input  logic [REG_ADDR_W-1:0] a_addr_i,
  input  logic [REG_DATA_W-1:0] a_data_i,
  output logic                  a_stall_o,
  input  logic                  b_valid_i,
  output logic                  b_ready_o,
  input  logic [REG_ADDR_W-1:0] b_addr_i,
  input  logic [REG_DATA_W-1:0] b_data_i,
  output logic [REG_ADDR_W-1:0] RDaddr_o,
  output logic [REG_DATA_W-1:0] RDdata_o,
  output logic                  RegWrite_o,
  output logic [31:0]           pend_o
);

  logic [3:0]                       starve_cnt;
  wb_req_t                          fifo_head;
  wb_req_t                          b_req;
  logic                             fifo_full;
  logic                             fifo_empty;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
  logic                             a_req;
  logic                             issue_a;
  logic                             issue_b;
  logic                             b_push;

  // Stall comes straight from registered state, so it is stable all cycle.
  assign a_stall_o = (starve_cnt == 4'(STARVE_LIMIT));

  // Writes to register 0 from A never win arbitration.
  assign a_req   = a_valid_i && (a_addr_i != REG_ZERO) && !a_stall_o;
  assign issue_a = a_req;
  assign issue_b = !a_req && !fifo_empty;

  // Full is taken from the current count: a same-cycle pop does not open a
  // slot for that cycle's push.
  assign b_ready_o = !fifo_full && !rst_i;
  assign b_push    = b_valid_i && b_ready_o && (b_addr_i != REG_ZERO);
  assign b_req     = '{addr: b_addr_i, data: b_data_i};

  rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk_i),
    .rst         (rst_i),
    .push        (b_push),
    .wr_req      (b_req),
    .pop         (issue_b),
    .head        (fifo_head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      RegWrite_o <= 1'b0;
      RDaddr_o   <= REG_ZERO;
      RDdata_o   <= '0;
      starve_cnt <= '0;
    end else begin
      RegWrite_o <= issue_a || issue_b;
      if (issue_a) begin
        RDaddr_o <= a_addr_i;
        RDdata_o <= a_data_i;
      end else if (issue_b) begin
        RDaddr_o <= fifo_head.addr;
        RDdata_o <= fifo_head.data;
      end
      // Count A wins only while B has something waiting.
      if (fifo_empty || issue_b) starve_cnt <= '0;
      else if (issue_a)          starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_comb begin
    pend_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pend_o = pend_o | reg_onehot(entry_addr[i]);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic        a_stall;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] pend;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .a_valid_i  (a_valid),
    .a_addr_i   (a_addr),
    .a_data_i   (a_data),
    .a_stall_o  (a_stall),
    .b_valid_i  (b_valid),
    .b_ready_o  (b_ready),
    .b_addr_i   (b_addr),
    .b_data_i   (b_data),
    .RDaddr_o   (rd_addr),
    .RDdata_o   (rd_data),
    .RegWrite_o (reg_write),
    .pend_o     (pend)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // exp_q holds the buffered B writes in arrival order as {addr, data}.
  logic [36:0] exp_q[$];
  int          m_waits;   // A wins in a row while B has been waiting
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  function automatic logic [31:0] exp_pend();
    logic [31:0] p;
    p = '0;
    foreach (exp_q[i]) p[exp_q[i][36:32]] = 1'b1;
    return p;
  endfunction

  function automatic logic exp_ready();
    return !rst && (exp_q.size() < DEPTH);
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    logic [36:0] h;
    int          sz;
    if (rst) begin
      exp_q.delete();
      m_waits = 0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      return;
    end
    sz = exp_q.size();
    if (a_valid && a_addr != 0 && m_waits != LIMIT) begin
      m_we   = 1'b1;
      m_addr = a_addr;
      m_data = a_data;
      m_waits = (sz > 0) ? m_waits + 1 : 0;
    end else if (sz > 0) begin
      h      = exp_q.pop_front();
      m_we   = 1'b1;
      m_addr = h[36:32];
      m_data = h[31:0];
      m_waits = 0;
    end else begin
      m_we    = 1'b0;
      m_waits = 0;
    end
    if (b_valid && sz < DEPTH && b_addr != 0) exp_q.push_back({b_addr, b_data});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick(); tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", reg_write); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", rd_addr); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", rd_data); end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", a_stall); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", b_ready); end
    checks++; if (pend !== 32'd0) begin errors++; $display("FAIL reset_pend: got %0h want 0", pend); end
    rst = 1'b0;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b want 1", b_ready); end
    // traffic, then reset in the middle of it
    a_valid = 1'b1; a_addr = 5'd6; a_data = 32'h6666;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'h5555;
    tick();
    b_addr = 5'd8; b_data = 32'h8888;
    tick();
    checks++; if (pend !== 32'h0000_0120) begin errors++; $display("FAIL midtraffic_pend: got %0h want 120", pend); end
    rst = 1'b1;
    tick(); tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL midreset_we: got %0b want 0", reg_write); end
    checks++; if (rd_addr !== 5'd0 || rd_data !== 32'd0) begin errors++; $display("FAIL midreset_rd: got %0d/%0h want 0/0", rd_addr, rd_data); end
    checks++; if (pend !== 32'd0) begin errors++; $display("FAIL midreset_pend: got %0h want 0", pend); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %0b want 0", b_ready); end
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL midreset_release_ready: got %0b want 1", b_ready); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL midreset_flushed: got %0b want 0", reg_write); end
  endtask

  task automatic test_a_only();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
    tick();
    a_valid = 1'b0;
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL a_only_write: got we=%0b %0d/%0h want 1 5/deadbeef", reg_write, rd_addr, rd_data);
    end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL a_only_off: got %0b want 0", reg_write); end
    checks++; if (rd_addr !== 5'd5 || rd_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL a_only_hold: got %0d/%0h want 5/deadbeef", rd_addr, rd_data);
    end
  endtask

  task automatic test_b_only();
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h1234_5678;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b_only_ready: got %0b want 1", b_ready); end
    tick();
    b_valid = 1'b0;
    checks++; if (pend !== 32'h0000_0080) begin errors++; $display("FAIL b_only_pend: got %0h want 80", pend); end
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL b_only_early: got %0b want 0", reg_write); end
    tick();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL b_only_write: got we=%0b %0d/%0h want 1 7/12345678", reg_write, rd_addr, rd_data);
    end
    checks++; if (pend !== 32'd0) begin errors++; $display("FAIL b_only_pend_clear: got %0h want 0", pend); end
    tick();
  endtask

  task automatic test_starvation();
    a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hA5A5_A5A5;
    b_valid = 1'b1; b_addr = 5'd3;  b_data = 32'h3333_3333;
    tick();                                   // edge k: push 3
    b_addr = 5'd4; b_data = 32'h4444_4444;
    tick();                                   // edge k+1: push 4, first A win with B waiting
    b_valid = 1'b0;
    #1;
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL starve_full_ready: got %0b want 0", b_ready); end
    checks++; if (pend !== 32'h0000_0018) begin errors++; $display("FAIL starve_pend: got %0h want 18", pend); end
    for (int i = 2; i <= 4; i++) begin
      checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL starve_early_stall%0d: got %0b want 0", i - 1, a_stall); end
      tick();
    end
    checks++; if (a_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %0b want 1", a_stall); end
    checks++; if (rd_addr !== 5'd12 || reg_write !== 1'b1) begin errors++; $display("FAIL starve_a_wins: got %0d want 12", rd_addr); end
    tick();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'h3333_3333) begin
      errors++; $display("FAIL starve_b_issue: got we=%0b %0d/%0h want 1 3/33333333", reg_write, rd_addr, rd_data);
    end
    checks++; if (a_stall !== 1'b0) begin errors++; $display("FAIL starve_stall_drop: got %0b want 0", a_stall); end
    checks++; if (pend !== 32'h0000_0010) begin errors++; $display("FAIL starve_pend_after: got %0h want 10", pend); end
    tick();
    checks++; if (rd_addr !== 5'd12) begin errors++; $display("FAIL starve_a_resume: got %0d want 12", rd_addr); end
    a_valid = 1'b0;
    tick();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd4) begin errors++; $display("FAIL starve_drain: got %0d want 4", rd_addr); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL starve_idle: got %0b want 0", reg_write); end
  endtask

  task automatic test_reg_zero();
    a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFF_0000;
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h0000_FFFF;
    #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL zero_handshake: got %0b want 1", b_ready); end
    tick();
    idle_inputs();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL zero_no_write: got %0b want 0", reg_write); end
    checks++; if (pend !== 32'd0) begin errors++; $display("FAIL zero_pend: got %0h want 0", pend); end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL zero_not_stored: got %0b want 0", reg_write); end
  endtask

  task automatic test_simultaneous();
    a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h9999_0009;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h1010_0010;
    tick();
    idle_inputs();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'h9999_0009) begin
      errors++; $display("FAIL simul_first: got we=%0b %0d/%0h want 1 9/99990009", reg_write, rd_addr, rd_data);
    end
    checks++; if (pend !== 32'h0000_0400) begin errors++; $display("FAIL simul_pend: got %0h want 400", pend); end
    tick();
    checks++; if (reg_write !== 1'b1 || rd_addr !== 5'd10 || rd_data !== 32'h1010_0010) begin
      errors++; $display("FAIL simul_second: got we=%0b %0d/%0h want 1 10/10100010", reg_write, rd_addr, rd_data);
    end
    tick();
    checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL simul_idle: got %0b want 0", reg_write); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      // Pipeline holds A while stalled; B holds until accepted.
      if (!(a_valid && a_stall)) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!(b_valid && !b_ready)) begin
        b_valid = ($urandom_range(0, 1) != 0);
        b_addr  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        b_data  = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      #1;
      checks++; if (reg_write !== m_we) begin errors++; $display("FAIL rand_we c=%0d: got %0b want %0b", c, reg_write, m_we); end
      checks++; if (rd_addr !== m_addr || rd_data !== m_data) begin
        errors++; $display("FAIL rand_rd c=%0d: got %0d/%0h want %0d/%0h", c, rd_addr, rd_data, m_addr, m_data);
      end
      checks++; if (a_stall !== (m_waits == LIMIT)) begin errors++; $display("FAIL rand_stall c=%0d: got %0b want %0b", c, a_stall, (m_waits == LIMIT)); end
      checks++; if (b_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready c=%0d: got %0b want %0b", c, b_ready, exp_ready()); end
      checks++; if (pend !== exp_pend()) begin errors++; $display("FAIL rand_pend c=%0d: got %0h want %0h", c, pend, exp_pend()); end
      tick();
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_a_only();
    test_b_only();
    test_starvation();
    test_reg_zero();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32×32 register file. It shares the single write port between two sources. Source A is the pipeline writeback stage, which is always served first. Source B is a long-latency unit such as mul/div; its results are buffered in a small FIFO and written in idle slots. The block drives the register file's RDaddr/RDdata/RegWrite inputs and gives the hazard unit a per-register pending-write vector.

## Interface
Parameters:
- DEPTH, 2: B-side FIFO entries; must be a power of 2, at least 2.
- STARVE_LIMIT, 4: consecutive A-wins with B pending before A is stalled; range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- a_valid_i  in  1  writeback request from pipeline; no handshake.
- a_addr_i  in  5  A destination register.
- a_data_i  in  32  A write data.
- a_stall_o  out  1  pipeline must hold A (valid/addr/data unchanged) this cycle.
- b_valid_i  in  1  B request.
- b_ready_o  out  1  B accepted on an edge where b_valid_i and b_ready_o are both high.
- b_addr_i  in  5  B destination register.
- b_data_i  in  32  B write data.
- RDaddr_o  out  5  register file write address; registered.
- RDdata_o  out  32  register file write data; registered.
- RegWrite_o  out  1  register file write enable; registered.
- pend_o  out  32  bit i is high while any FIFO entry targets register i.

## Operation
- a_req = a_valid_i && a_addr_i != 0 && !a_stall_o.
- At each edge, the registered outputs load with the first match in priority order:
  - a_req: load A.
  - FIFO not empty: load the head and pop it.
  - Otherwise: RegWrite_o = 0; RDaddr_o and RDdata_o hold their previous values.
- B push:
  - B is pushed when b_valid_i && b_ready_o && b_addr_i != 0.
  - B with address 0 completes the handshake and is discarded, never stored.
- b_ready_o = !full && !rst_i.
  - full is taken from the current count.
  - A pop in the same cycle does not free a slot for that cycle's push.
- Push and pop on the same edge are both legal when not full; the count is unchanged.
- A writes to register 0 are dropped: no RegWrite_o, and no win is counted.
- Starvation counter starve_cnt (4 bits):
  - Increments on an edge where the FIFO is not empty and A issued.
  - Clears on an edge where the FIFO is empty or the head issued.
- a_stall_o = (starve_cnt == STARVE_LIMIT). It is derived from registered state.
  - While it is high, A is ignored and the head issues.
  - The counter clears on that same edge.
- Ordering between A and B writes to the same register is not enforced here. The hazard unit uses pend_o to prevent write-after-write inversion.
- pend_o is the OR of one-hot decodes of the valid FIFO entries' addresses.

## Timing
- A latency: sampled at edge k, RegWrite_o high during cycle k→k+1.
- B latency:
  - Pushed at edge k, the earliest issue is edge k+1, so RegWrite_o is high during cycle k+1→k+2.
  - pend_o bit is high from after edge k until after its issue edge.
- Worst-case B wait with B pending: STARVE_LIMIT+1 edges per entry.
- Reset, on any edge with rst_i high, including mid-operation:
  - Outputs: RegWrite_o=0, RDaddr_o=0, RDdata_o=0, a_stall_o=0, b_ready_o=0.
  - State: FIFO flushed, so pend_o=0; starve_cnt=0.
  - In-flight B data is lost.
- b_ready_o is high from the first cycle after reset deassertion.

## Structure
- Shared package regfile_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0.
  - wb_req_t struct {addr, data}.
- Sub-module rf_wb_fifo:
  - Synchronous FIFO of wb_req_t, DEPTH entries, with read and write pointers plus a count.
  - Exposes full, empty, head and a per-entry valid/addr view for pend_o.
- The top level holds the arbitration, starve_cnt and the output registers.

## Test plan
- Reset: hold rst_i 2 cycles mid-traffic → all outputs 0, pend_o=0, b_ready_o=0. b_ready_o=1 the cycle after release.
- A only: a_valid_i=1, addr=5, data=0xDEADBEEF for one cycle → next cycle RegWrite_o=1, RDaddr_o=5, RDdata_o=0xDEADBEEF; then RegWrite_o=0.
- B only:
  - Stimulus: push addr=7, data=0x12345678 at edge k with A idle.
  - pend_o=0x00000080 after edge k.
  - RegWrite_o=1 with addr 7 after edge k+1; pend_o=0 after edge k+1.
- Starvation, DEPTH=2, STARVE_LIMIT=4:
  - Stimulus: A valid every cycle; push B to addr 3 then addr 4.
  - b_ready_o=0 once 2 entries are stored.
  - After 4 A-wins, a_stall_o=1 for one cycle and addr 3 is written; A then resumes.
- Register 0: A addr 0 and B addr 0 → no RegWrite_o, pend_o stays 0, and the B handshake still completes.
- Simultaneous: A addr 9 and B push addr 10 on the same edge with the FIFO empty → write 9 first, then 10 the next cycle.
